// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole game controller.
package mole_pkg;

  localparam int LIVES_W = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PICK    = 3'd1,
    WAIT    = 3'd2,
    HOLDOFF = 3'd3,
    OVER    = 3'd4
  } state_t;

  // Fold an out-of-range LFSR value into [0, n) and never repeat the previous mole.
  function automatic int pick_mole(input int r, input int prev, input int n);
    int c;
    c = (r < n) ? r : r - n;
    if (c >= n) c = 0;
    if (c == prev) c = (c + 1) % n;
    return c;
  endfunction

endpackage

// File: rtl/mole_game_core_if.sv
// Signal bundle between the input conditioning (buttons, LFSR) and the game controller.
interface mole_game_core_if #(
  parameter int NUM_MOLES = 8,
  parameter int IDX_W     = 3,
  parameter int SCORE_W   = 8
);
  logic                         start;
  logic [NUM_MOLES-1:0]         btn;
  logic [IDX_W-1:0]             rand_val;
  // mole_idx is meaningful only while mole_valid is high; there is no back-pressure.
  logic [IDX_W-1:0]             mole_idx;
  logic                         mole_valid;
  logic [SCORE_W-1:0]           score;
  logic [mole_pkg::LIVES_W-1:0] lives;
  logic                         hit_pulse;
  logic                         miss_pulse;
  logic                         game_over;

  modport master (
    output start, btn, rand_val,
    input  mole_idx, mole_valid, score, lives, hit_pulse, miss_pulse, game_over
  );

  modport slave (
    input  start, btn, rand_val,
    output mole_idx, mole_valid, score, lives, hit_pulse, miss_pulse, game_over
  );
endinterface

// File: rtl/mole_window_timer.sv
// Reaction-window length (shrinks every 4th hit, floored) and the per-mole countdown.
module mole_window_timer #(
  parameter int WIN_INIT = 1000,
  parameter int WIN_MIN  = 200,
  parameter int WIN_STEP = 50,
  parameter int WIN_W    = $clog2(WIN_INIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_restart,
  input  logic             i_load,
  input  logic             i_run,
  input  logic             i_shrink,
  output logic             o_expire,
  output logic [WIN_W-1:0] o_cur_window
);

  logic [WIN_W-1:0] r_window;
  logic [WIN_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_window <= WIN_W'(WIN_INIT);
    end else if (i_restart) begin
      r_window <= WIN_W'(WIN_INIT);
    end else if (i_shrink) begin
      if (int'(r_window) >= WIN_MIN + WIN_STEP) r_window <= r_window - WIN_W'(WIN_STEP);
      else                                      r_window <= WIN_W'(WIN_MIN);
    end
  end

  // Loaded with window-1 so the mole stays lit for exactly r_window cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= r_window - WIN_W'(1);
    end else if (i_run && (r_count != '0)) begin
      r_count <= r_count - WIN_W'(1);
    end
  end

  assign o_expire     = i_run && (r_count == '0);
  assign o_cur_window = r_window;

endmodule

// File: rtl/mole_game_core.sv
// Whack-a-mole game controller: mole selection, hit/miss judging, score, lives and game timer.
module mole_game_core import mole_pkg::*; #(
  parameter int NUM_MOLES   = 8,
  parameter int IDX_W       = 3,
  parameter int SCORE_W     = 8,
  parameter int LIVES       = 3,
  parameter int WIN_INIT    = 1000,
  parameter int WIN_MIN     = 200,
  parameter int WIN_STEP    = 50,
  parameter int GAME_CYCLES = 15000000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  mole_game_core_if.slave                   bus,
  output state_t                            o_state,
  output logic [$clog2(WIN_INIT + 1)-1:0]   o_cur_window
);

  localparam int CNT_W = $clog2(GAME_CYCLES + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t               r_state, w_next_state;
  logic [NUM_MOLES-1:0] r_btn_q;
  logic [IDX_W-1:0]     r_mole_idx;
  logic [SCORE_W-1:0]   r_score;
  logic [LIVES_W-1:0]   r_lives;
  logic                 r_hit_pulse, r_miss_pulse;
  logic [CNT_W-1:0]     r_game_cnt;

  logic [NUM_MOLES-1:0] w_rise, w_onehot;
  logic                 w_in_wait, w_active, w_hit, w_wrong, w_expire, w_timeout, w_miss;
  logic                 w_time_up, w_start_ok, w_shrink;
  logic [SCORE_W-1:0]   w_score_inc;
  logic [IDX_W-1:0]     w_pick;

  assign w_rise      = bus.btn & ~r_btn_q;
  assign w_onehot    = NUM_MOLES'(1) << r_mole_idx;
  assign w_in_wait   = (r_state == WAIT);
  assign w_active    = (r_state == PICK) || (r_state == WAIT) || (r_state == HOLDOFF);
  // A hit needs the lit mole's rising edge and nothing else; any extra press is a miss.
  assign w_hit       = w_in_wait && (w_rise == w_onehot);
  assign w_wrong     = w_in_wait && (w_rise != '0) && !w_hit;
  assign w_timeout   = w_expire && !w_hit;
  assign w_miss      = w_wrong || w_timeout;
  assign w_time_up   = w_active && (r_game_cnt == CNT_W'(GAME_CYCLES - 1));
  assign w_start_ok  = bus.start && ((r_state == IDLE) || (r_state == OVER));
  assign w_score_inc = (r_score == SCORE_MAX) ? r_score : r_score + SCORE_W'(1);
  assign w_shrink    = w_hit && (w_score_inc[1:0] == 2'b00);
  assign w_pick      = IDX_W'(pick_mole(int'(bus.rand_val), int'(r_mole_idx), NUM_MOLES));

  mole_window_timer #(
    .WIN_INIT (WIN_INIT),
    .WIN_MIN  (WIN_MIN),
    .WIN_STEP (WIN_STEP)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_restart    (w_start_ok),
    .i_load       (r_state == PICK),
    .i_run        (w_in_wait),
    .i_shrink     (w_shrink),
    .o_expire     (w_expire),
    .o_cur_window (o_cur_window)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, OVER: if (bus.start) w_next_state = PICK;
      PICK:       w_next_state = WAIT;
      WAIT: begin
        if (w_hit)                                w_next_state = HOLDOFF;
        else if (w_miss && r_lives == LIVES_W'(1)) w_next_state = OVER;
        else if (w_timeout)                       w_next_state = PICK;
      end
      HOLDOFF:    if (bus.btn == '0) w_next_state = PICK;
      default:    w_next_state = IDLE;
    endcase
    if (w_time_up) w_next_state = OVER;
  end

  always_comb begin
    bus.mole_valid = (r_state == WAIT);
    bus.game_over  = (r_state == OVER);
    bus.mole_idx   = r_mole_idx;
    bus.score      = r_score;
    bus.lives      = r_lives;
    bus.hit_pulse  = r_hit_pulse;
    bus.miss_pulse = r_miss_pulse;
    o_state        = r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_q      <= '0;
      r_mole_idx   <= '0;
      r_score      <= '0;
      r_lives      <= LIVES_W'(LIVES);
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_game_cnt   <= '0;
    end else begin
      r_btn_q      <= bus.btn;
      r_hit_pulse  <= w_hit;
      r_miss_pulse <= w_miss;
      if (w_start_ok) begin
        r_score    <= '0;
        r_lives    <= LIVES_W'(LIVES);
        r_game_cnt <= '0;
      end else begin
        if (w_active)            r_game_cnt <= r_game_cnt + CNT_W'(1);
        if (r_state == PICK)     r_mole_idx <= w_pick;
        if (w_hit)               r_score    <= w_score_inc;
        if (w_miss && r_lives != '0) r_lives <= r_lives - LIVES_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mole_game_core.sv
// Directed bench: a main game on a 6-mole/4-bit-score instance and a short-game instance.
module tb_mole_game_core;
  import mole_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t st_m, st_s;
  logic [8:0] win_m;
  logic [4:0] win_s;

  mole_game_core_if #(.NUM_MOLES(6), .IDX_W(3), .SCORE_W(4)) bm ();
  mole_game_core_if #(.NUM_MOLES(8), .IDX_W(3), .SCORE_W(8)) bs ();

  mole_game_core #(
    .NUM_MOLES(6), .IDX_W(3), .SCORE_W(4), .LIVES(3),
    .WIN_INIT(300), .WIN_MIN(200), .WIN_STEP(50), .GAME_CYCLES(20000)
  ) u_main (.clk(clk), .rst_n(rst_n), .bus(bm), .o_state(st_m), .o_cur_window(win_m));

  mole_game_core #(
    .NUM_MOLES(8), .IDX_W(3), .SCORE_W(8), .LIVES(3),
    .WIN_INIT(20), .WIN_MIN(10), .WIN_STEP(5), .GAME_CYCLES(50)
  ) u_short (.clk(clk), .rst_n(rst_n), .bus(bs), .o_state(st_s), .o_cur_window(win_s));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard
  int n_checks = 0;
  int n_err    = 0;
  int hits_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] rnd;
    logic [2:0] mole;
    logic [5:0] mask;
    logic       hit;
    logic       miss;
    logic [3:0] score;
    logic [2:0] lives;
    logic [8:0] win;
  } vec_t;

  vec_t vt[19];

  function automatic vec_t mk(input int rnd, input int mole, input int mask, input int hit,
                              input int miss, input int score, input int lives, input int win);
    vec_t v;
    v.rnd = 3'(rnd); v.mole = 3'(mole); v.mask = 6'(mask); v.hit = 1'(hit);
    v.miss = 1'(miss); v.score = 4'(score); v.lives = 3'(lives); v.win = 9'(win);
    return v;
  endfunction

  // driver tasks
  task automatic wait_valid_m(input string nm);
    int n = 0;
    while (!bm.mole_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(bm.mole_valid), 32'd1);
  endtask

  task automatic run_row(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("row%0d", idx);
    bm.rand_val = v.rnd;
    wait_valid_m({tag, "_valid"});
    check({tag, "_mole"}, 32'(bm.mole_idx), 32'(v.mole));
    bm.btn = v.mask;
    @(negedge clk);
    hits_seen += int'(bm.hit_pulse);
    check({tag, "_hit"},   32'(bm.hit_pulse),  32'(v.hit));
    check({tag, "_miss"},  32'(bm.miss_pulse), 32'(v.miss));
    check({tag, "_score"}, 32'(bm.score),      32'(v.score));
    check({tag, "_lives"}, 32'(bm.lives),      32'(v.lives));
    check({tag, "_win"},   32'(win_m),         32'(v.win));
    bm.btn = '0;
    @(negedge clk);
    check({tag, "_pulse_clear"}, 32'(bm.hit_pulse | bm.miss_pulse), 32'd0);
  endtask

  initial begin
    int cyc;

    vt[0]  = mk(2, 2, 'h10, 0, 1, 1,  2, 300);
    vt[1]  = mk(0, 2, 'h14, 0, 1, 1,  1, 300);
    vt[2]  = mk(3, 2, 'h04, 1, 0, 2,  1, 300);
    vt[3]  = mk(2, 3, 'h08, 1, 0, 3,  1, 300);
    vt[4]  = mk(6, 0, 'h01, 1, 0, 4,  1, 250);
    vt[5]  = mk(7, 1, 'h02, 1, 0, 5,  1, 250);
    vt[6]  = mk(1, 2, 'h04, 1, 0, 6,  1, 250);
    vt[7]  = mk(5, 5, 'h20, 1, 0, 7,  1, 250);
    vt[8]  = mk(5, 0, 'h01, 1, 0, 8,  1, 200);
    vt[9]  = mk(4, 4, 'h10, 1, 0, 9,  1, 200);
    vt[10] = mk(0, 0, 'h01, 1, 0, 10, 1, 200);
    vt[11] = mk(3, 3, 'h08, 1, 0, 11, 1, 200);
    vt[12] = mk(6, 0, 'h01, 1, 0, 12, 1, 200);
    vt[13] = mk(7, 1, 'h02, 1, 0, 13, 1, 200);
    vt[14] = mk(2, 2, 'h04, 1, 0, 14, 1, 200);
    vt[15] = mk(4, 4, 'h10, 1, 0, 15, 1, 200);
    vt[16] = mk(4, 5, 'h20, 1, 0, 15, 1, 200);
    vt[17] = mk(1, 1, 'h02, 1, 0, 15, 1, 200);
    vt[18] = mk(0, 0, 'h02, 0, 1, 15, 0, 200);

    rst_n = 1'b0;
    bm.start = 1'b0; bm.btn = '0; bm.rand_val = '0;
    bs.start = 1'b0; bs.btn = '0; bs.rand_val = '0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_score", 32'(bm.score), 32'd0);
    check("rst_lives", 32'(bm.lives), 32'd3);
    check("rst_mole",  32'(bm.mole_idx), 32'd0);
    check("rst_valid", 32'(bm.mole_valid), 32'd0);
    check("rst_pulses", 32'(bm.hit_pulse | bm.miss_pulse | bm.game_over), 32'd0);
    check("rst_state", 32'(st_m), 32'(IDLE));
    check("rst_win",   32'(win_m), 32'd300);
    rst_n = 1'b1;
    @(negedge clk);

    // start, first mole, hold the button for 100 cycles
    bm.rand_val = 3'd5;
    bm.start = 1'b1;
    @(negedge clk);
    bm.start = 1'b0;
    check("start_state", 32'(st_m), 32'(PICK));
    wait_valid_m("first_valid");
    check("first_mole", 32'(bm.mole_idx), 32'd5);
    bm.btn = 6'h20;
    cyc = 0;
    for (int i = 0; i < 101; i++) begin
      @(negedge clk);
      cyc += int'(bm.hit_pulse);
    end
    hits_seen += cyc;
    check("hold_hits",  32'(cyc), 32'd1);
    check("hold_score", 32'(bm.score), 32'd1);
    check("hold_valid", 32'(bm.mole_valid), 32'd0);
    bm.btn = '0;
    bm.rand_val = 3'd2;
    @(negedge clk);
    check("release_pick", 32'(st_m), 32'(PICK));

    // table: wrong presses, hit run with window shrink, saturation, last life
    for (int i = 0; i < 19; i++) run_row(vt[i], i);
    check("total_hit_pulses", 32'(hits_seen), 32'd17);
    check("over_flag",  32'(bm.game_over), 32'd1);
    check("over_valid", 32'(bm.mole_valid), 32'd0);
    check("over_state", 32'(st_m), 32'(OVER));

    // presses in OVER are ignored
    bm.btn = 6'h01;
    @(negedge clk);
    check("over_frozen_score", 32'(bm.score), 32'd15);
    check("over_frozen_lives", 32'(bm.lives), 32'd0);
    check("over_no_hit", 32'(bm.hit_pulse), 32'd0);
    bm.btn = '0;
    @(negedge clk);

    // restart without reset
    bm.rand_val = 3'd3;
    bm.start = 1'b1;
    @(negedge clk);
    bm.start = 1'b0;
    check("restart_score", 32'(bm.score), 32'd0);
    check("restart_lives", 32'(bm.lives), 32'd3);
    check("restart_over",  32'(bm.game_over), 32'd0);
    check("restart_win",   32'(win_m), 32'd300);
    wait_valid_m("restart_valid");
    check("restart_mole", 32'(bm.mole_idx), 32'd3);
    bm.btn = 6'h08;
    @(negedge clk);
    check("restart_hit_score", 32'(bm.score), 32'd1);
    bm.btn = '0;
    bm.rand_val = 3'd1;
    @(negedge clk);
    wait_valid_m("pre_reset_valid");
    check("pre_reset_mole", 32'(bm.mole_idx), 32'd1);

    // asynchronous reset mid-WAIT
    rst_n = 1'b0;
    #1;
    check("async_rst_score", 32'(bm.score), 32'd0);
    check("async_rst_lives", 32'(bm.lives), 32'd3);
    check("async_rst_mole",  32'(bm.mole_idx), 32'd0);
    check("async_rst_valid", 32'(bm.mole_valid), 32'd0);
    check("async_rst_state", 32'(st_m), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // short game: timeout miss, new mole, game timer expiry
    bs.rand_val = 3'd3;
    bs.start = 1'b1;
    @(negedge clk);
    bs.start = 1'b0;
    cyc = 0;
    while (!bs.mole_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("short_valid", 32'(bs.mole_valid), 32'd1);
    check("short_mole",  32'(bs.mole_idx), 32'd3);
    check("short_win",   32'(win_s), 32'd20);
    cyc = 0;
    while (!bs.miss_pulse && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout_cycles", 32'(cyc), 32'd20);
    check("timeout_lives",  32'(bs.lives), 32'd2);
    check("timeout_state",  32'(st_s), 32'(PICK));
    @(negedge clk);
    check("timeout_new_mole", 32'(bs.mole_idx), 32'd4);
    check("timeout_new_valid", 32'(bs.mole_valid), 32'd1);
    cyc = 0;
    while (!bs.game_over && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("gametime_over",  32'(bs.game_over), 32'd1);
    check("gametime_lives", 32'(bs.lives), 32'd1);
    check("gametime_score", 32'(bs.score), 32'd0);
    check("gametime_valid", 32'(bs.mole_valid), 32'd0);
    repeat (5) @(negedge clk);
    check("gametime_still_over", 32'(st_s), 32'(OVER));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
